// File: rtl/valid_ready_fifo_with_level.sv
// Flip-flop FIFO with valid/ready on both sides, occupancy count, almost-full/empty flags and flush.
// Define VALID_READY_FIFO_HIGH_WATER_EN to build the high_water register; otherwise high_water reads 0.
module valid_ready_fifo_with_level #(
    parameter int width              = 8,
    parameter int depth              = 10,
    parameter int almost_full_level  = depth - 1,
    parameter int almost_empty_level = 1,
    localparam int count_width       = $clog2(depth + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [width-1:0]       up_data,
    output logic                   down_valid,
    input  logic                   down_ready,
    output logic [width-1:0]       down_data,
    output logic [count_width-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [count_width-1:0] high_water
);
    localparam int ptr_width = $clog2(depth);
    localparam logic [ptr_width-1:0]   PTR_LAST = ptr_width'(depth - 1);
    localparam logic [count_width-1:0] DEPTH_C  = count_width'(depth);
    localparam logic [count_width-1:0] AF_C     = count_width'(almost_full_level);
    localparam logic [count_width-1:0] AE_C     = count_width'(almost_empty_level);

    logic [width-1:0]       mem [depth];
    logic [ptr_width-1:0]   wr_ptr;
    logic [ptr_width-1:0]   rd_ptr;
    logic [count_width-1:0] count_nxt;
    logic                   push;
    logic                   pop;

    assign up_ready     = rst_n && (count != DEPTH_C);
    assign down_valid   = rst_n && (count != '0);
    assign push         = up_valid && up_ready;
    assign pop          = down_valid && down_ready;
    assign down_data    = mem[rd_ptr];
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + count_width'(1);
        end else if (!push && pop) begin
            count_nxt = count - count_width'(1);
        end
    end

    // Storage is not reset; a write during flush is harmless because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= up_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ptr_width'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + ptr_width'(1);
            end
            count <= count_nxt;
        end
    end

`ifdef VALID_READY_FIFO_HIGH_WATER_EN
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            high_water <= '0;
        end else if (count_nxt > high_water) begin
            high_water <= count_nxt;
        end
    end
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_valid_ready_fifo_with_level.sv
// Bench for valid_ready_fifo_with_level: queue model checked every cycle plus directed literal checks.
module tb_valid_ready_fifo_with_level;
    localparam int W  = 8;
    localparam int D  = 10;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [W-1:0]  up_data = '0;
    logic          down_valid;
    logic          down_ready = 1'b0;
    logic [W-1:0]  down_data;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] high_water;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [W-1:0] q[$];
    logic [W-1:0] sent[$];
    logic [W-1:0] got[$];
    int hw = 0;

    valid_ready_fifo_with_level #(.width(W), .depth(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .high_water(high_water)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of accepted words and a running maximum of its size.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
            hw = 0;
        end else begin
            automatic bit do_pop  = down_ready && (q.size() > 0);
            automatic bit do_push = up_valid && (q.size() < D);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(up_data);
                sent.push_back(up_data);
            end
            if (q.size() > hw) hw = q.size();
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            automatic int n = q.size();
            chk("up_ready", int'(up_ready), int'(rst_n && n < D));
            chk("down_valid", int'(down_valid), int'(rst_n && n > 0));
            chk("count", int'(count), n);
            chk("almost_full", int'(almost_full), int'(n >= D - 1));
            chk("almost_empty", int'(almost_empty), int'(n <= 1));
`ifdef VALID_READY_FIFO_HIGH_WATER_EN
            chk("high_water", int'(high_water), hw);
`else
            chk("high_water", int'(high_water), 0);
`endif
            if (rst_n && n > 0) chk("down_data", int'(down_data), int'(q[0]));
            if (down_valid && down_ready) got.push_back(down_data);
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        up_valid = v; up_data = d; down_ready = r; flush = f;
        @(posedge clk);
        #2;
        up_valid = 1'b0; down_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_en = 1'b1;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_up_ready", int'(up_ready), 1);
        chk("rst_down_valid", int'(down_valid), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_high_water", int'(high_water), 0);

        // Fill 0x00..0x09 with no downstream demand.
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, W'(i), 1'b0, 1'b0);
            chk("fill_almost_full", int'(almost_full), int'(i + 1 >= 9));
        end
        chk("full_count", int'(count), 10);
        chk("full_up_ready", int'(up_ready), 0);

        got.delete();
        for (int i = 0; i < D; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_len", got.size(), 10);
        for (int i = 0; i < got.size(); i++) chk("drain_order", int'(got[i]), i);
        chk("drain_down_valid", int'(down_valid), 0);

        // Simultaneous push and pop when empty: only the push takes effect.
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("empty_pp_count", int'(count), 1);
        chk("empty_pp_data", int'(down_data), 8'h55);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h60 + W'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h70, 1'b1, 1'b0);
        chk("mid_pp_count", int'(count), 5);
        chk("mid_pp_head", int'(down_data), 8'h60);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h80 + W'(i), 1'b0, 1'b0);
        chk("refill_count", int'(count), 10);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_pp_count", int'(count), 9);

        // Drain, then random traffic across several pointer wraps.
        for (int i = 0; i < 12 && down_valid; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pre_wrap_empty", int'(count), 0);
        sent.delete();
        got.delete();
        for (int i = 0; i < 25; i++) cyc(1'($urandom_range(0, 3) != 0), W'(8'hB0 + i), 1'($urandom_range(0, 2) != 0), 1'b0);
        for (int i = 0; i < 20 && down_valid; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_len", got.size(), sent.size());
        for (int i = 0; i < got.size() && i < sent.size(); i++) chk("wrap_order", int'(got[i]), int'(sent[i]));

        // Flush at count 7 with a concurrent push.
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'hC0 + W'(i), 1'b0, 1'b0);
        chk("pre_flush_count", int'(count), 7);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("flush_count", int'(count), 0);
        chk("flush_down_valid", int'(down_valid), 0);
        chk("flush_high_water", int'(high_water), 0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        chk("post_flush_head", int'(down_data), 8'h11);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // High-water: push 6, pop 6, push 3.
        for (int i = 0; i < 6; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
`ifdef VALID_READY_FIFO_HIGH_WATER_EN
        chk("hw_peak", int'(high_water), 6);
`else
        chk("hw_peak", int'(high_water), 0);
`endif

        // Reset mid-operation at count 4.
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("pre_rst_count", int'(count), 4);
        rst_n = 1'b0;
        #1;
        chk("rst_low_up_ready", int'(up_ready), 0);
        chk("rst_low_down_valid", int'(down_valid), 0);
        @(posedge clk);
        #2;
        chk("rst_low_up_ready2", int'(up_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_down_valid", int'(down_valid), 0);
        chk("post_rst_almost_empty", int'(almost_empty), 1);
        chk("post_rst_up_ready", int'(up_ready), 1);
        chk("post_rst_high_water", int'(high_water), 0);
        @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
